// File: rtl/vdisk_sd_arbiter.sv
// ============================================================================
// vdisk_sd_arbiter
//   Round-robin sharing of the HPS virtual-disk sector channel between the
//   two FDC drives. Optional watchdog: define VDISK_ARB_TIMEOUT_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module vdisk_sd_arbiter #(
  parameter int unsigned LBA_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 42000000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [1:0]       req_rd,
  input  logic [1:0]       req_wr,
  input  logic [LBA_W-1:0] req_lba0,
  input  logic [LBA_W-1:0] req_lba1,
  output logic [1:0]       done,
  output logic [1:0]       err,
  input  logic [1:0]       img_mounted,
  input  logic             img_size_nz,
  output logic [LBA_W-1:0] sd_lba,
  output logic [1:0]       sd_rd,
  output logic [1:0]       sd_wr,
  input  logic [1:0]       sd_ack,
  input  logic             sd_buff_wr,
  output logic [1:0]       buf_wr,
  input  logic [7:0]       drv_din0,
  input  logic [7:0]       drv_din1,
  output logic [7:0]       sd_buff_din,
  output logic [1:0]       grant
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             drv_q, drv_d;
  logic             wr_q, wr_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [1:0]       mounted_q, mounted_d;
  logic             rr_last_q, rr_last_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       sd_rd_q, sd_rd_d;
  logic [1:0]       sd_wr_q, sd_wr_d;

  logic [1:0]       pending;
  logic             sel;
  logic             ack_cur;
  logic [1:0]       drv_oh;

`ifdef VDISK_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign pending = req_rd | req_wr;
  // With both drives pending, the one that was not served last goes next.
  assign sel     = (pending == 2'b11) ? ~rr_last_q : pending[1];
  assign ack_cur = sd_ack[drv_q];
  assign drv_oh  = {drv_q, ~drv_q};

  always_comb begin
    state_d   = state_q;
    drv_d     = drv_q;
    wr_d      = wr_q;
    lba_d     = lba_q;
    mounted_d = mounted_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
`ifdef VDISK_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pending != 2'b00) begin
          drv_d = sel;
          wr_d  = ~req_rd[sel];
          lba_d = sel ? req_lba1 : req_lba0;
          if (!mounted_q[sel]) begin
            state_d = S_FAIL;
          end else begin
            grant_d = sel ? 2'b10 : 2'b01;
            state_d = S_ISSUE;
`ifdef VDISK_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (ack_cur) begin
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
          state_d = S_XFER;
        end else begin
          sd_rd_d = wr_q ? 2'b00 : drv_oh;
          sd_wr_d = wr_q ? drv_oh : 2'b00;
        end
      end
      S_XFER: begin
        if (!ack_cur) state_d = S_DONE;
      end
      S_DONE: begin
        rr_last_d = drv_q;
        grant_d   = 2'b00;
        state_d   = S_IDLE;
      end
      S_FAIL: begin
        rr_last_d = drv_q;
        grant_d   = 2'b00;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef VDISK_ARB_TIMEOUT_EN
    if (state_q == S_ISSUE || state_q == S_XFER) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        sd_rd_d          = 2'b00;
        sd_wr_d          = 2'b00;
        grant_d          = 2'b00;
        mounted_d[drv_q] = 1'b0;
        state_d          = S_FAIL;
      end
    end
`endif

    // A fresh mount report overrides any watchdog unmount in the same cycle.
    for (int d = 0; d < 2; d++) begin
      if (img_mounted[d]) mounted_d[d] = img_size_nz;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drv_q     <= 1'b0;
      wr_q      <= 1'b0;
      lba_q     <= '0;
      mounted_q <= 2'b00;
      rr_last_q <= 1'b1;
      grant_q   <= 2'b00;
      sd_rd_q   <= 2'b00;
      sd_wr_q   <= 2'b00;
`ifdef VDISK_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      drv_q     <= drv_d;
      wr_q      <= wr_d;
      lba_q     <= lba_d;
      mounted_q <= mounted_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
`ifdef VDISK_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign done        = (state_q == S_DONE || state_q == S_FAIL) ? drv_oh : 2'b00;
  assign err         = (state_q == S_FAIL) ? drv_oh : 2'b00;
  assign buf_wr      = (state_q == S_XFER) ? ({2{sd_buff_wr}} & grant_q) : 2'b00;
  assign sd_buff_din = grant_q[1] ? drv_din1 : drv_din0;
  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign grant       = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_vdisk_sd_arbiter.sv
// ============================================================================
// tb_vdisk_sd_arbiter
//   Self-checking bench: vector table plus scoreboard of completions.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vdisk_sd_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  done, err;
  logic [1:0]  img_mounted;
  logic        img_size_nz;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr, sd_ack;
  logic        sd_buff_wr;
  logic [1:0]  buf_wr;
  logic [7:0]  drv_din0, drv_din1, sd_buff_din;
  logic [1:0]  grant;

  logic [1:0]  m_ack, h_ack;
  logic        m_bwr, h_bwr;
  logic        hps_en;

  assign sd_ack     = hps_en ? m_ack : h_ack;
  assign sd_buff_wr = hps_en ? m_bwr : h_bwr;

  always #5 clk_sys = ~clk_sys;

  vdisk_sd_arbiter #(.LBA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba0(req_lba0), .req_lba1(req_lba1),
    .done(done), .err(err), .img_mounted(img_mounted), .img_size_nz(img_size_nz),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .buf_wr(buf_wr), .drv_din0(drv_din0), .drv_din1(drv_din1),
    .sd_buff_din(sd_buff_din), .grant(grant)
  );

  typedef struct {
    logic [1:0]  mnt;
    logic        nz;
    logic [1:0]  rd, wr;
    logic [31:0] l0, l1;
    logic [1:0]  e_done, e_err, e_rd, e_wr;
    logic [31:0] e_lba;
  } vec_t;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] lba;
    int          bufs;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   n_chk = 0;
  int   n_fail = 0;
  int   buf_mark = 0;
  logic done_seen = 1'b0;

  // Per-cycle observers: buffer strobe count, grant history, illegal overlaps.
  int         buf_total = 0;
  logic       saw_both = 1'b0;
  logic       stray_bad = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] ghist [0:31];
  int         ghist_n = 0;

  always @(negedge clk_sys) begin
    if (buf_wr != 2'b00) buf_total <= buf_total + 1;
    if ((buf_wr & ~grant) != 2'b00) stray_bad <= 1'b1;
    if (sd_rd == 2'b11 || sd_wr == 2'b11) saw_both <= 1'b1;
    if (grant != 2'b00 && prev_grant == 2'b00 && ghist_n < 32) begin
      ghist[ghist_n] <= grant;
      ghist_n        <= ghist_n + 1;
    end
    prev_grant <= grant;
  end

  // hps_io model: ack 5 cycles, buffer strobes on 3 of the transfer cycles.
  initial begin
    logic [1:0] who;
    m_ack = 2'b00;
    m_bwr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (hps_en && !reset && (sd_rd | sd_wr) != 2'b00) begin
        who = sd_rd | sd_wr;
        @(posedge clk_sys); #1;
        m_ack = who;
        for (int k = 0; k < 5; k++) begin
          m_bwr = (k == 1 || k == 2 || k == 4);
          @(posedge clk_sys); #1;
        end
        m_bwr = 1'b0;
        m_ack = 2'b00;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_done", 32'(done), 32'd0);
    end else begin
      e = sb.pop_front();
      chk("done", 32'(done), 32'(e.done));
      chk("err", 32'(err), 32'(e.err));
      chk("done_lba", sd_lba, e.lba);
      chk("buf_wr_count", 32'(buf_total - buf_mark), 32'(e.bufs));
    end
    buf_mark  = buf_total;
    done_seen = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_sys); #1;
    if (done != 2'b00) score();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) step();
    chk("done_arrived", 32'(done_seen), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    if (v.mnt != 2'b00) begin
      img_mounted = v.mnt;
      img_size_nz = v.nz;
      step();
      img_mounted = 2'b00;
      step();
    end
    done_seen = 1'b0;
    sb.push_back('{v.e_done, v.e_err, v.e_lba, (v.e_err != 2'b00) ? 0 : 3});
    req_rd = v.rd; req_wr = v.wr; req_lba0 = v.l0; req_lba1 = v.l1;
    step();
    step();
    chk("strobe_rd", 32'(sd_rd), 32'(v.e_rd));
    chk("strobe_wr", 32'(sd_wr), 32'(v.e_wr));
    if (v.e_err != 2'b00) chk("fail_within_2", 32'(done_seen), 32'd1);
    else                  wait_done(20);
    req_rd = 2'b00;
    req_wr = 2'b00;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int cyc;
    //          mnt    nz    rd     wr     l0            l1            done   err    rd     wr     lba
    tbl[0]  = '{2'b01, 1'b1, 2'b01, 2'b00, 32'h12,       32'h0,        2'b01, 2'b00, 2'b01, 2'b00, 32'h12};
    tbl[1]  = '{2'b10, 1'b0, 2'b00, 2'b10, 32'h0,        32'h34,       2'b10, 2'b10, 2'b00, 2'b00, 32'h34};
    tbl[2]  = '{2'b00, 1'b0, 2'b01, 2'b01, 32'h55,       32'h0,        2'b01, 2'b00, 2'b01, 2'b00, 32'h55};
    tbl[3]  = '{2'b00, 1'b0, 2'b00, 2'b01, 32'hABCD,     32'h0,        2'b01, 2'b00, 2'b00, 2'b01, 32'hABCD};
    tbl[4]  = '{2'b10, 1'b1, 2'b10, 2'b00, 32'h0,        32'h77,       2'b10, 2'b00, 2'b10, 2'b00, 32'h77};
    tbl[5]  = '{2'b00, 1'b0, 2'b00, 2'b10, 32'h0,        32'hDEADBEEF, 2'b10, 2'b00, 2'b00, 2'b10, 32'hDEADBEEF};
    tbl[6]  = '{2'b00, 1'b0, 2'b01, 2'b10, 32'h61,       32'h62,       2'b01, 2'b00, 2'b01, 2'b00, 32'h61};
    tbl[7]  = '{2'b01, 1'b0, 2'b00, 2'b01, 32'h7,        32'h0,        2'b01, 2'b01, 2'b00, 2'b00, 32'h7};
    tbl[8]  = '{2'b01, 1'b1, 2'b10, 2'b00, 32'h0,        32'h8,        2'b10, 2'b00, 2'b10, 2'b00, 32'h8};
    tbl[9]  = '{2'b10, 1'b1, 2'b10, 2'b00, 32'h0,        32'h99,       2'b10, 2'b00, 2'b10, 2'b00, 32'h99};
    tbl[10] = '{2'b00, 1'b0, 2'b01, 2'b00, 32'h66,       32'h0,        2'b01, 2'b01, 2'b00, 2'b00, 32'h66};

    req_rd = 2'b00; req_wr = 2'b00; req_lba0 = '0; req_lba1 = '0;
    img_mounted = 2'b00; img_size_nz = 1'b0;
    drv_din0 = 8'h5A; drv_din1 = 8'hC3;
    h_ack = 2'b00; h_bwr = 1'b0; hps_en = 1'b1;

    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_lba", sd_lba, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

    // Both drives pending continuously: service must alternate 0,1,0,1.
    g0 = ghist_n;
    for (int k = 0; k < 4; k++)
      sb.push_back('{(k % 2 == 1) ? 2'b10 : 2'b01, 2'b00, (k % 2 == 1) ? 32'h200 : 32'h100, 3});
    req_rd = 2'b11; req_lba0 = 32'h100; req_lba1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      done_seen = 1'b0;
      wait_done(30);
    end
    req_rd = 2'b00;
    step();
    step();
    for (int k = 0; k < 4; k++)
      chk("rr_grant_order", 32'(ghist[g0 + k]), (k % 2 == 1) ? 32'd2 : 32'd1);
    chk("rd_never_both", 32'(saw_both), 32'd0);

    // Stray ack / buffer strobes are ignored; exactly one real strobe counts.
    hps_en = 1'b0;
    h_bwr = 1'b1; step(); h_bwr = 1'b0; step();
    done_seen = 1'b0;
    sb.push_back('{2'b01, 2'b00, 32'h33, 1});
    req_rd = 2'b01; req_lba0 = 32'h33;
    step();
    step();
    chk("stray_pre_rd", 32'(sd_rd), 32'd1);
    h_ack = 2'b10; h_bwr = 1'b1;
    step();
    chk("stray_ack_ignored", 32'(sd_rd), 32'd1);
    h_ack = 2'b01; h_bwr = 1'b0;
    step();
    chk("ack_drops_rd", 32'(sd_rd), 32'd0);
    chk("buff_din_drv0", 32'(sd_buff_din), 32'h5A);
    h_bwr = 1'b1;
    step();
    h_bwr = 1'b0; h_ack = 2'b00;
    step();
    chk("ack_fall_to_done", 32'(done_seen), 32'd1);
    req_rd = 2'b00;
    step();

    // Reset in the middle of a transfer.
    req_rd = 2'b01; req_lba0 = 32'h44;
    step();
    step();
    h_ack = 2'b01;
    step();
    step();
    chk("xfer_grant", 32'(grant), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_sd_rd", 32'(sd_rd), 32'd0);
    chk("midrst_sd_wr", 32'(sd_wr), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_lba", sd_lba, 32'd0);
    req_rd = 2'b00; h_ack = 2'b00;
    step();
    step();
    reset = 1'b0;
    step();
    hps_en = 1'b1;
    apply_vec(tbl[9]);
    apply_vec(tbl[10]);

`ifdef VDISK_ARB_TIMEOUT_EN
    hps_en = 1'b0;
    img_mounted = 2'b01; img_size_nz = 1'b1;
    step();
    img_mounted = 2'b00;
    step();
    done_seen = 1'b0;
    sb.push_back('{2'b01, 2'b01, 32'h5, 0});
    req_rd = 2'b01; req_lba0 = 32'h5;
    step();
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      step();
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'd16);
    chk("timeout_rd_dropped", 32'(sd_rd), 32'd0);
    req_rd = 2'b00;
    step();
    hps_en = 1'b1;
    apply_vec('{2'b00, 1'b0, 2'b01, 2'b00, 32'h6, 32'h0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h6});
`endif

    chk("no_stray_buf_wr", 32'(stray_bad), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
